// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The master drives operands and out_ready; the slave (the adder) drives the results.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one CHUNK-bit lookahead slice per stage, with the
// operand slices skewed in and the result slices deskewed out so that all sum bits emerge together.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                  clk,
  input logic                  reset,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of CHUNK");
  end

  logic              adv;
  logic [WIDTH-1:0]  y_eff;
  logic              cin_eff;
  logic [STAGES:0]   valid_q, valid_d;
  // carry_q[0] is the registered carry-in; carry_q[k+1] is the carry out of stage k.
  logic [STAGES:0]   carry_q, carry_d;
  logic [STAGES-1:0] stage_cout;
  logic [WIDTH-1:0]  s_out;
  logic              msb_cin;
  logic              ovf_q, ovf_d;

  assign adv     = ~valid_q[STAGES] | bus.out_ready;
  assign y_eff   = bus.sub ? ~bus.y : bus.y;
  assign cin_eff = bus.sub | bus.cin;

  always_comb begin
    valid_d = {valid_q[STAGES-1:0], bus.in_valid};
    carry_d = {stage_cout, cin_eff};
    ovf_d   = msb_cin ^ stage_cout[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo       = k * CHUNK;
    localparam int unsigned ResDepth = STAGES - k;

    // xd/yd: operand slice k+1 register levels deep; rd: result slice until the output level.
    logic [CHUNK-1:0] xd_q [k+1];
    logic [CHUNK-1:0] xd_d [k+1];
    logic [CHUNK-1:0] yd_q [k+1];
    logic [CHUNK-1:0] yd_d [k+1];
    logic [CHUNK-1:0] rd_q [ResDepth];
    logic [CHUNK-1:0] rd_d [ResDepth];
    logic [CHUNK-1:0] g, p, sum;
    logic             c_out;

    always_comb begin
      logic [CHUNK:0] c;
      g    = xd_q[k] & yd_q[k];
      p    = xd_q[k] ^ yd_q[k];
      c    = '0;
      c[0] = carry_q[k];
      for (int i = 0; i < int'(CHUNK); i++) begin
        c[i+1] = g[i] | (p[i] & c[i]);
      end
      sum   = p ^ c[CHUNK-1:0];
      c_out = c[CHUNK];
    end

    always_comb begin
      xd_d[0] = bus.x[Lo +: CHUNK];
      yd_d[0] = y_eff[Lo +: CHUNK];
      for (int i = 1; i <= k; i++) begin
        xd_d[i] = xd_q[i-1];
        yd_d[i] = yd_q[i-1];
      end
      rd_d[0] = sum;
      for (int i = 1; i < int'(ResDepth); i++) begin
        rd_d[i] = rd_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i <= k; i++) begin
          xd_q[i] <= '0;
          yd_q[i] <= '0;
        end
        for (int i = 0; i < int'(ResDepth); i++) begin
          rd_q[i] <= '0;
        end
      end else if (adv) begin
        xd_q <= xd_d;
        yd_q <= yd_d;
        rd_q <= rd_d;
      end
    end

    assign stage_cout[k]       = c_out;
    assign s_out[Lo +: CHUNK]  = rd_q[ResDepth-1];

    if (k == STAGES - 1) begin : g_msb
      // Carry into the MSB recovered from its sum and propagate bits.
      assign msb_cin = p[CHUNK-1] ^ sum[CHUNK-1];
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[STAGES];
  assign bus.S         = s_out;
  assign bus.cout      = carry_q[STAGES];
  assign bus.ovf       = ovf_q;
endmodule
